// File: rtl/wb_select_stage_if.sv
// wb_select_stage_if
//   Groups the MEM/WB pipeline bundle entering the write-back stage and the
//   register-file write port leaving it.
//   master : drives stall/flush and the in_* bundle, observes the wb_* port
//   slave  : the write-back stage itself
//   Ports carried:
//     stall, flush, in_valid, in_alu, in_mem, in_pc4, in_imm, in_sel,
//     in_ld_size, in_ld_uns, in_addr_lo, in_rd, in_regwrite   (to stage)
//     wb_valid, wb_we, wb_rd, wb_data                         (from stage)
//     retire_cnt (only when WB_RETIRE_CNT_EN is defined)      (from stage)
//   Optional feature macro: WB_RETIRE_CNT_EN
interface wb_select_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic [DATA_W-1:0]     in_alu;
  logic [DATA_W-1:0]     in_mem;
  logic [DATA_W-1:0]     in_pc4;
  logic [DATA_W-1:0]     in_imm;
  logic [1:0]            in_sel;
  logic [1:0]            in_ld_size;
  logic                  in_ld_uns;
  logic [2:0]            in_addr_lo;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_regwrite;

  logic                  wb_valid;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_data;
`ifdef WB_RETIRE_CNT_EN
  logic [DATA_W-1:0]     retire_cnt;
`endif

  modport master (
    output stall, flush, in_valid, in_alu, in_mem, in_pc4, in_imm,
           in_sel, in_ld_size, in_ld_uns, in_addr_lo, in_rd, in_regwrite,
    input  wb_valid, wb_we, wb_rd, wb_data
`ifdef WB_RETIRE_CNT_EN
    , input retire_cnt
`endif
  );

  modport slave (
    input  stall, flush, in_valid, in_alu, in_mem, in_pc4, in_imm,
           in_sel, in_ld_size, in_ld_uns, in_addr_lo, in_rd, in_regwrite,
    output wb_valid, wb_we, wb_rd, wb_data
`ifdef WB_RETIRE_CNT_EN
    , output retire_cnt
`endif
  );
endinterface

// File: rtl/wb_select_stage.sv
// wb_select_stage
//   Registered write-back stage. Captures the MEM/WB bundle, selects one of
//   up to four result sources (ALU, extracted load, PC+4, upper immediate),
//   performs sub-word load lane extraction with sign/zero extension, and
//   drives the register-file write port one cycle after capture.
//   Per-edge priority: flush > stall > capture.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : wb_select_stage_if.slave (pipeline bundle in, write port out)
//   Parameters:
//     DATA_W     : 32 or 64
//     REG_ADDR_W : register index width
//     NUM_SRC    : 2..4 sources; selects >= NUM_SRC fall back to the ALU
//   Optional feature macro: WB_RETIRE_CNT_EN
//     Adds retire_cnt, counting instructions leaving the stage
//     (wb_valid=1 and stall=0 at an edge), wrapping at all-ones.
module wb_select_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_select_stage_if.slave    bus
);

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;
  localparam logic [1:0] SEL_IMM  = 2'd3;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  logic [1:0]            size_eff;
  logic [2:0]            byte_off;
  logic [5:0]            shamt;
  logic [DATA_W-1:0]     mem_shift;
  logic [DATA_W-1:0]     ld_mask;
  logic                  ld_sign;
  logic                  ld_fill;
  logic [DATA_W-1:0]     ld_data;
  logic [1:0]            sel_eff;
  logic [DATA_W-1:0]     data_d;
  logic                  we_d;

  logic                  valid_q;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     data_q;

  // A 32-bit datapath has no doubleword; treat it as a word access.
  always_comb begin
    size_eff = bus.in_ld_size;
    if (DATA_W == 32 && bus.in_ld_size == SZ_DWORD) begin
      size_eff = SZ_WORD;
    end
  end

  // Byte offset of the lane, with low bits below the access size dropped.
  always_comb begin
    byte_off = bus.in_addr_lo;
    if (DATA_W == 32) begin
      byte_off[2] = 1'b0;
    end
    case (size_eff)
      SZ_HALF:  byte_off[0]   = 1'b0;
      SZ_WORD:  byte_off[1:0] = 2'b00;
      SZ_DWORD: byte_off      = 3'b000;
      default:  ;
    endcase
  end

  assign shamt     = {byte_off, 3'b000};
  assign mem_shift = bus.in_mem >> shamt;

  // Mask keeps the extracted lane; the complement is filled with the sign
  // bit for signed loads. A full-width access yields an all-ones mask, so
  // the word passes through untouched.
  always_comb begin
    ld_mask = '1;
    ld_sign = mem_shift[DATA_W-1];
    case (size_eff)
      SZ_BYTE: begin
        ld_mask = DATA_W'(8'hFF);
        ld_sign = mem_shift[7];
      end
      SZ_HALF: begin
        ld_mask = DATA_W'(16'hFFFF);
        ld_sign = mem_shift[15];
      end
      SZ_WORD: begin
        ld_mask = DATA_W'(32'hFFFF_FFFF);
        ld_sign = mem_shift[31];
      end
      default: ;
    endcase
    ld_fill = ld_sign & ~bus.in_ld_uns;
    ld_data = (mem_shift & ld_mask) | (ld_fill ? ~ld_mask : '0);
  end

  always_comb begin
    sel_eff = bus.in_sel;
    if (int'(bus.in_sel) >= NUM_SRC) begin
      sel_eff = SEL_ALU;
    end
    data_d = bus.in_alu;
    case (sel_eff)
      SEL_MEM: data_d = ld_data;
      SEL_PC4: data_d = bus.in_pc4;
      SEL_IMM: data_d = bus.in_imm;
      default: data_d = bus.in_alu;
    endcase
  end

  // x0 is hard-wired; never enable a write to it.
  assign we_d = bus.in_valid & bus.in_regwrite & (bus.in_rd != '0);

  // Flush only kills valid/we; rd and data keep their old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
    end else if (!bus.stall) begin
      valid_q <= bus.in_valid;
      we_q    <= we_d;
      rd_q    <= bus.in_rd;
      data_q  <= data_d;
    end
  end

  assign bus.wb_valid = valid_q;
  assign bus.wb_we    = we_q;
  assign bus.wb_rd    = rd_q;
  assign bus.wb_data  = data_q;

`ifdef WB_RETIRE_CNT_EN
  logic [DATA_W-1:0] retire_cnt_q;

  // An instruction retires when it leaves the stage, i.e. whenever the
  // stage holds a valid instruction and is not stalled (flush included).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (valid_q && !bus.stall) begin
      retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign bus.retire_cnt = retire_cnt_q;
`endif

endmodule
